stage0_fetch: RTL
=================

// Module: stage0_fetch
// PURPOSE
//  Instruction fetch / issue stage for the BPF CPU controller: the producer side of the
//  buffered valid/ready handshake into the stage-0.5 instruction register.
//  Owns the PC, drives the synchronous code-memory read port (1-cycle read latency) and
//  presents {instr_out, pc_out} with vld/next_rdy. Handles start, halt and mispredict redirect.
// PARAMETERS
//  PC_WIDTH    10  code-memory address width; PC wraps modulo 2**PC_WIDTH
//  INSTR_WIDTH 64  instruction word width
// PORTS
//  clk              in   1            sole clock, rising edge
//  rst              in   1            asynchronous, active-low reset
//  start            in   1            pulse: begin fetching at PC 0 (honoured only in IDLE)
//  halt             in   1            stop fetching, flush, return to IDLE
//  branch_mispredict in  1            flush all queued/in-flight instrs, redirect PC
//  branch_target    in   PC_WIDTH     new PC, sampled when branch_mispredict=1
//  inst_rd_en       out  1            code-memory read enable (combinational)
//  inst_rd_addr     out  PC_WIDTH     code-memory read address (= PC register)
//  inst_rd_data     in   INSTR_WIDTH  read data, valid the cycle after inst_rd_en
//  instr_out        out  INSTR_WIDTH  head instruction toward stage 0.5
//  pc_out           out  PC_WIDTH     address instr_out was fetched from
//  vld              out  1            instr_out/pc_out valid
//  next_rdy         in   1            downstream ready; transfer when vld && next_rdy
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, PC=0, occ=0, inflight=0, vld=0, instr_out=0,
//   pc_out=0, inst_rd_en=0, inst_rd_addr=0. All other regs clear at the same time.
//  States: IDLE -> RUN on start. RUN -> IDLE on halt. start in RUN ignored.
//  Storage: 2-entry FIFO of {pc, instr} (head = output regs, second = skid entry);
//   occ in 0..2. inflight = 1 iff a read was issued last cycle (data arrives now).
//  shift_out = vld && next_rdy. vld = (occ != 0); instr_out/pc_out = head entry.
//  Issue rule: inst_rd_en = RUN && !halt && !branch_mispredict &&
//   (occ + inflight - shift_out) < 2. Guarantees returning data always has a FIFO slot.
//  On issue: inst_rd_addr = PC; PC <= PC + 1 (wrap 2**PC_WIDTH-1 -> 0); inflight <= 1,
//   tag pc for the returning word is the issued address.
//  Data return (inflight=1): push {tag, inst_rd_data} to FIFO; simultaneous push and
//   shift_out keeps occ unchanged and order preserved (skid entry moves to head).
//  Latency: start in cycle T -> rd_en, addr 0 in T+1 -> vld=1, instr_out=mem[0] in T+3.
//   Steady state with next_rdy=1: one instruction per cycle, no bubbles.
//  Stall: next_rdy=0 -> FIFO fills to 2, rd_en drops; head held stable while vld=1.
//  branch_mispredict (RUN, cycle M): next edge occ<=0, inflight<=0 (returning data
//   discarded), PC<=branch_target, vld=0 in M+1; rd_en with target in M+1; vld in M+3.
//   branch_mispredict in IDLE: ignored.
//  halt (cycle H): same flush as mispredict, PC<=0, state<=IDLE; halt wins over
//   simultaneous mispredict. start and halt together in IDLE: stay IDLE.
//  No transfer is counted in a flush cycle even if vld && next_rdy (downstream also flushes).
// TESTING
//  1 Reset: rst=0 mid-RUN with occ=2 -> same-cycle vld=0, rd_en=0, PC=0; start after
//    release fetches mem[0].
//  2 Streaming: mem[i]=i+100, start, next_rdy=1 -> vld from T+3, instr_out=100,101,102..
//    one per cycle, pc_out=0,1,2..
//  3 Backpressure: next_rdy=0 for 5 cycles after first vld -> occ=2, rd_en=0, instr_out=100
//    stable; next_rdy=1 -> 100,101,102.. with no gap, no loss, no duplicate.
//  4 Mispredict: while streaming, mispredict with target=0x20 -> vld=0 next cycle,
//    rd_addr=0x20 next cycle, next delivered pc_out=0x20, no stale instr delivered.
//  5 Wrap: PC_WIDTH=4, branch_target=15 -> pc_out sequence 15,0,1.
//  6 Halt/start: halt with mispredict same cycle -> IDLE, no further rd_en; start in RUN
//    ignored (PC sequence continues uninterrupted).

Source files
------------

// File: rtl/stage0_fetch.sv
// Instruction fetch / issue stage: owns the PC, drives the synchronous code-memory read port
// and hands {instr, pc} to stage 0.5 through a 2-entry skid FIFO with valid/ready.
module stage0_fetch #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   branch_mispredict,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   inst_rd_en,
  output logic [PC_WIDTH-1:0]    inst_rd_addr,
  input  logic [INSTR_WIDTH-1:0] inst_rd_data,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic                   vld,
  input  logic                   next_rdy
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [1:0]             occ_q, occ_d;
  logic                   inflight_q, inflight_d;
  logic [PC_WIDTH-1:0]    tag_q, tag_d;
  logic [INSTR_WIDTH-1:0] head_instr_q, head_instr_d;
  logic [PC_WIDTH-1:0]    head_pc_q, head_pc_d;
  logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic [PC_WIDTH-1:0]    skid_pc_q, skid_pc_d;

  logic       run;
  logic       flush;
  logic       shift_out;
  logic       push;
  logic [2:0] level;

  assign run       = (state_q == S_RUN);
  assign flush     = halt || (run && branch_mispredict);
  assign vld       = (occ_q != 2'd0);
  assign shift_out = vld && next_rdy;
  assign push      = inflight_q;
  assign instr_out = head_instr_q;
  assign pc_out    = head_pc_q;

  // Only issue when the returning word is guaranteed a FIFO slot next cycle.
  assign level        = {1'b0, occ_q} + {2'b00, inflight_q};
  assign inst_rd_en   = run && !halt && !branch_mispredict &&
                        (level < (3'd2 + {2'b00, shift_out}));
  assign inst_rd_addr = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inflight_d   = inst_rd_en;
    tag_d        = inst_rd_en ? pc_q : tag_q;
    occ_d        = occ_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (halt) begin
      state_d = S_IDLE;
    end else if (!run && start) begin
      state_d = S_RUN;
    end

    if (halt) begin
      pc_d = '0;
    end else if (run && branch_mispredict) begin
      pc_d = branch_target;
    end else if (inst_rd_en) begin
      pc_d = pc_q + PC_WIDTH'(1);
    end

    // A flush drops both queued entries and the word coming back from memory.
    if (flush) begin
      occ_d = 2'd0;
    end else if (push && shift_out) begin
      if (occ_q == 2'd2) begin
        head_instr_d = skid_instr_q;
        head_pc_d    = skid_pc_q;
        skid_instr_d = inst_rd_data;
        skid_pc_d    = tag_q;
      end else begin
        head_instr_d = inst_rd_data;
        head_pc_d    = tag_q;
      end
    end else if (push) begin
      if (occ_q == 2'd0) begin
        head_instr_d = inst_rd_data;
        head_pc_d    = tag_q;
      end else begin
        skid_instr_d = inst_rd_data;
        skid_pc_d    = tag_q;
      end
      occ_d = occ_q + 2'd1;
    end else if (shift_out) begin
      head_instr_d = skid_instr_q;
      head_pc_d    = skid_pc_q;
      occ_d        = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      tag_q        <= '0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      occ_q        <= occ_d;
      inflight_q   <= inflight_d;
      tag_q        <= tag_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule
